// File: rtl/rambit_arb.sv
// rambit_arb: round-robin arbiter sharing one single-port, bit-masked RAM among
// NR requesters, with an optional clear sweep of every word after reset.
module rambit_arb #(
    parameter int DW   = 16,
    parameter int AW   = 10,
    parameter int NR   = 2,
    parameter int INIT = 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [NR-1:0]    req_valid,
    output logic [NR-1:0]    req_ready,
    input  logic [NR-1:0]    req_write,
    input  logic [NR*AW-1:0] req_addr,
    input  logic [NR*DW-1:0] req_we,
    input  logic [NR*DW-1:0] req_din,
    output logic [NR-1:0]    rsp_valid,
    output logic [DW-1:0]    rsp_data,
    output logic             init_done,
    output logic             ram_ce,
    output logic [DW-1:0]    ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_din,
    input  logic [DW-1:0]    ram_dout
);

    localparam int PW = (NR > 1) ? $clog2(NR) : 1;

    typedef enum logic {
        ST_INIT,
        ST_SERVE
    } state_t;

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [PW-1:0] ptr;
    logic [NR-1:0] rsp_q;
    logic          init_done_q;

    logic          gnt_any;
    logic [PW-1:0] gnt_idx;
    logic [NR-1:0] gnt_onehot;
    logic          gnt_write;

    // Search starts just after the last winner, so the previous grantee has lowest priority.
    always_comb begin : grant_sel
        logic [PW-1:0] cand;
        cand    = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= NR; k++) begin
            cand = PW'((int'(ptr) + k) % NR);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_onehot = NR'(1) << gnt_idx;
    assign gnt_write  = req_write[gnt_idx];

    // Reset gates the RAM port and handshakes combinationally, before the clocked reset lands.
    always_comb begin
        req_ready = '0;
        ram_ce    = 1'b0;
        ram_we    = '0;
        ram_addr  = '0;
        ram_din   = '0;
        if (nreset) begin
            if (state == ST_INIT) begin
                ram_ce   = 1'b1;
                ram_we   = '1;
                ram_addr = clr_cnt;
            end else if (gnt_any) begin
                req_ready = gnt_onehot;
                ram_ce    = 1'b1;
                ram_addr  = req_addr[gnt_idx*AW +: AW];
                if (gnt_write) begin
                    ram_we  = req_we[gnt_idx*DW +: DW];
                    ram_din = req_din[gnt_idx*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= (INIT != 0) ? ST_INIT : ST_SERVE;
            clr_cnt     <= '0;
            init_done_q <= (INIT == 0);
            ptr         <= PW'(NR - 1);
            rsp_q       <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    rsp_q   <= '0;
                    clr_cnt <= clr_cnt + AW'(1);
                    if (clr_cnt == '1) begin
                        state       <= ST_SERVE;
                        init_done_q <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    rsp_q <= (gnt_any && !gnt_write) ? gnt_onehot : '0;
                    if (gnt_any) begin
                        ptr <= gnt_idx;
                    end
                end
                default: begin
                    state <= ST_SERVE;
                    rsp_q <= '0;
                end
            endcase
        end
    end

    // A response still in its pipeline slot when reset asserts is suppressed here.
    assign rsp_valid = rsp_q & {NR{nreset}};
    assign rsp_data  = ram_dout;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_rambit_arb.sv
// Bench for rambit_arb: behavioural RAM plus an abstract arbitration/memory
// model; randomized and directed scenarios on an INIT=1 and an INIT=0 instance.
module tb_rambit_arb;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int NR    = 3;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             nreset;
    logic [NR-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_we, req_din;
    logic [DW-1:0]    rsp_data, ram_we, ram_din, ram_dout;
    logic [AW-1:0]    ram_addr;
    logic             init_done, ram_ce;

    logic             nreset_b;
    logic [NR-1:0]    req_valid_b, req_ready_b, req_write_b, rsp_valid_b;
    logic [NR*AW-1:0] req_addr_b;
    logic [NR*DW-1:0] req_we_b, req_din_b;
    logic [DW-1:0]    rsp_data_b, ram_we_b, ram_din_b;
    logic [DW-1:0]    ram_dout_b = 8'h3C;
    logic [AW-1:0]    ram_addr_b;
    logic             init_done_b, ram_ce_b;

    rambit_arb #(.DW(DW), .AW(AW), .NR(NR), .INIT(1)) dut (
        .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_we(req_we), .req_din(req_din),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_done(init_done),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    rambit_arb #(.DW(DW), .AW(AW), .NR(NR), .INIT(0)) dut_b (
        .clk(clk), .nreset(nreset_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_write(req_write_b), .req_addr(req_addr_b), .req_we(req_we_b), .req_din(req_din_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .init_done(init_done_b),
        .ram_ce(ram_ce_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_din(ram_din_b),
        .ram_dout(ram_dout_b)
    );

    // Behavioural bit-masked RAM; seeded with garbage so the clear sweep is visible.
    logic [DW-1:0] ram_mem [DEPTH];
    logic          seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 8'($urandom);
            seeded <= 1'b1;
        end else if (ram_ce) begin
            ram_dout          <= ram_mem[ram_addr];
            ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_we) | (ram_din & ram_we);
        end
    end

    logic [DW-1:0] ref_mem [DEPTH];
    int            m_ptr;
    logic [NR-1:0] m_pend;
    logic [DW-1:0] m_pend_data;
    int            n_checks = 0;
    int            n_pass   = 0;

    // Winner = valid requester closest after the last winner in circular order.
    function automatic int exp_grant(input logic [NR-1:0] v, input int last);
        int best, bestd, d;
        best  = -1;
        bestd = NR + 1;
        for (int i = 0; i < NR; i++) begin
            d = (i - last - 1 + 2 * NR) % NR;
            if (v[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic model_commit();
        int            g;
        logic [AW-1:0] a;
        logic [DW-1:0] m;
        g      = exp_grant(req_valid, m_ptr);
        m_pend = '0;
        if (g >= 0) begin
            m_ptr = g;
            a     = req_addr[g*AW +: AW];
            m     = req_we[g*DW +: DW];
            if (req_write[g]) begin
                ref_mem[a] = (ref_mem[a] & ~m) | (req_din[g*DW +: DW] & m);
            end else begin
                m_pend[g]   = 1'b1;
                m_pend_data = ref_mem[a];
            end
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] m, input logic [DW-1:0] d);
        req_valid[i]        = v;
        req_write[i]        = w;
        req_addr[i*AW +: AW] = a;
        req_we[i*DW +: DW]   = m;
        req_din[i*DW +: DW]  = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset    = 1'b0;
        nreset_b  = 1'b0;
        req_valid = '1; req_write = '0; req_addr = '0; req_we = '0; req_din = '0;
        req_valid_b = '0; req_write_b = '0; req_addr_b = '0; req_we_b = '0; req_din_b = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c > 0) begin
                n_checks++; if (req_ready !== 3'b000) $display("[TB] FAIL reset_ready got %b want 000", req_ready); else n_pass++;
                n_checks++; if (ram_ce !== 1'b0) $display("[TB] FAIL reset_ce got %b want 0", ram_ce); else n_pass++;
                n_checks++; if (rsp_valid !== 3'b000) $display("[TB] FAIL reset_rsp got %b want 000", rsp_valid); else n_pass++;
                n_checks++; if (init_done !== 1'b0) $display("[TB] FAIL reset_init_done got %b want 0", init_done); else n_pass++;
            end
            next_cycle();
        end
    endtask

    task automatic test_init();
        int nonzero;
        nreset    = 1'b1;
        req_valid = '1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            n_checks++; if (ram_ce !== 1'b1) $display("[TB] FAIL init_ce cyc %0d got %b want 1", i, ram_ce); else n_pass++;
            n_checks++; if (ram_we !== 8'hFF) $display("[TB] FAIL init_we cyc %0d got %h want ff", i, ram_we); else n_pass++;
            n_checks++; if (ram_din !== 8'h00) $display("[TB] FAIL init_din cyc %0d got %h want 00", i, ram_din); else n_pass++;
            n_checks++; if (ram_addr !== AW'(i)) $display("[TB] FAIL init_addr cyc %0d got %0d want %0d", i, ram_addr, i); else n_pass++;
            n_checks++; if (req_ready !== 3'b000) $display("[TB] FAIL init_ready cyc %0d got %b want 000", i, req_ready); else n_pass++;
            n_checks++; if (init_done !== 1'b0) $display("[TB] FAIL init_done_early cyc %0d got %b want 0", i, init_done); else n_pass++;
            next_cycle();
        end
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (init_done !== 1'b1) $display("[TB] FAIL init_done_rise got %b want 1", init_done); else n_pass++;
        n_checks++; if (ram_ce !== 1'b0) $display("[TB] FAIL init_idle_ce got %b want 0", ram_ce); else n_pass++;
        nonzero = 0;
        for (int i = 0; i < DEPTH; i++) if (ram_mem[i] !== 8'h00) nonzero++;
        n_checks++; if (nonzero != 0) $display("[TB] FAIL init_cleared got %0d nonzero words want 0", nonzero); else n_pass++;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        m_ptr  = NR - 1;
        m_pend = '0;
        next_cycle();
    endtask

    task automatic test_write_read();
        set_req(1, 1'b1, 1'b1, 4'd5, 8'hF0, 8'hA5);
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b010) $display("[TB] FAIL wr_ready got %b want 010", req_ready); else n_pass++;
        n_checks++; if (ram_ce !== 1'b1 || ram_addr !== 4'd5) $display("[TB] FAIL wr_ce_addr got %b/%0d want 1/5", ram_ce, ram_addr); else n_pass++;
        n_checks++; if (ram_we !== 8'hF0 || ram_din !== 8'hA5) $display("[TB] FAIL wr_we_din got %h/%h want f0/a5", ram_we, ram_din); else n_pass++;
        model_commit();
        next_cycle();
        set_req(1, 1'b1, 1'b0, 4'd5, 8'h00, 8'h00);
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b010) $display("[TB] FAIL rd_ready got %b want 010", req_ready); else n_pass++;
        n_checks++; if (ram_we !== 8'h00 || ram_din !== 8'h00) $display("[TB] FAIL rd_we_din got %h/%h want 00/00", ram_we, ram_din); else n_pass++;
        n_checks++; if (rsp_valid !== 3'b000) $display("[TB] FAIL wr_no_rsp got %b want 000", rsp_valid); else n_pass++;
        model_commit();
        next_cycle();
        set_req(1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 3'b010) $display("[TB] FAIL rd_rsp_valid got %b want 010", rsp_valid); else n_pass++;
        n_checks++; if (rsp_data !== 8'hA0) $display("[TB] FAIL rd_rsp_data got %h want a0", rsp_data); else n_pass++;
        model_commit();
        next_cycle();
    endtask

    task automatic test_fairness();
        int cnt [NR];
        int last [NR];
        int g, maxwait;
        for (int i = 0; i < NR; i++) begin
            cnt[i]  = 0;
            last[i] = -1;
            set_req(i, 1'b1, 1'b0, 4'($urandom), 8'h00, 8'h00);
        end
        maxwait = 0;
        for (int c = 0; c < 3 * NR; c++) begin
            @(negedge clk);
            g = exp_grant(req_valid, m_ptr);
            n_checks++; if (req_ready !== (NR'(1) << g)) $display("[TB] FAIL fair_ready cyc %0d got %b want %b", c, req_ready, NR'(1) << g); else n_pass++;
            n_checks++; if (rsp_valid !== m_pend) $display("[TB] FAIL fair_rsp cyc %0d got %b want %b", c, rsp_valid, m_pend); else n_pass++;
            if (m_pend != '0) begin
                n_checks++; if (rsp_data !== m_pend_data) $display("[TB] FAIL fair_data cyc %0d got %h want %h", c, rsp_data, m_pend_data); else n_pass++;
            end
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) begin
                    cnt[i]++;
                    if (last[i] >= 0 && c - last[i] - 1 > maxwait) maxwait = c - last[i] - 1;
                    last[i] = c;
                end
            end
            model_commit();
            next_cycle();
            set_req(g, 1'b1, 1'b0, 4'($urandom), 8'h00, 8'h00);
        end
        for (int i = 0; i < NR; i++) begin
            n_checks++; if (cnt[i] != 3) $display("[TB] FAIL fair_count req %0d got %0d want 3", i, cnt[i]); else n_pass++;
        end
        n_checks++; if (maxwait > NR - 1) $display("[TB] FAIL fair_maxwait got %0d want <= %0d", maxwait, NR - 1); else n_pass++;
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== m_pend || rsp_data !== m_pend_data) $display("[TB] FAIL fair_drain got %b/%h want %b/%h", rsp_valid, rsp_data, m_pend, m_pend_data); else n_pass++;
        model_commit();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] seq [6];
        seq = '{3'b100, 3'b001, 3'b100, 3'b001, 3'b001, 3'b001};
        set_req(0, 1'b1, 1'b0, 4'd1, 8'h00, 8'h00);
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b001) $display("[TB] FAIL b2b_prime got %b want 001", req_ready); else n_pass++;
        model_commit();
        next_cycle();
        for (int c = 0; c < 6; c++) begin
            set_req(0, 1'b1, 1'b0, 4'($urandom), 8'h00, 8'h00);
            set_req(2, (c < 3), 1'b0, 4'($urandom), 8'h00, 8'h00);
            @(negedge clk);
            n_checks++; if (req_ready !== seq[c]) $display("[TB] FAIL b2b_ready cyc %0d got %b want %b", c, req_ready, seq[c]); else n_pass++;
            n_checks++; if (rsp_valid !== m_pend || (m_pend != '0 && rsp_data !== m_pend_data)) $display("[TB] FAIL b2b_rsp cyc %0d got %b/%h want %b/%h", c, rsp_valid, rsp_data, m_pend, m_pend_data); else n_pass++;
            model_commit();
            next_cycle();
        end
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== m_pend || rsp_data !== m_pend_data) $display("[TB] FAIL b2b_drain got %b/%h want %b/%h", rsp_valid, rsp_data, m_pend, m_pend_data); else n_pass++;
        model_commit();
        next_cycle();
    endtask

    task automatic test_random();
        int            g;
        logic [NR-1:0] held;
        logic [DW-1:0] m;
        held = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!held[i]) begin
                    m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                    set_req(i, ($urandom_range(0, 2) != 0), 1'($urandom), 4'($urandom), m, 8'($urandom));
                end
            end
            @(negedge clk);
            g = exp_grant(req_valid, m_ptr);
            if (g < 0) begin
                n_checks++; if (req_ready !== 3'b000 || ram_ce !== 1'b0 || ram_we !== 8'h00) $display("[TB] FAIL rnd_idle cyc %0d got %b/%b/%h want 000/0/00", c, req_ready, ram_ce, ram_we); else n_pass++;
            end else begin
                n_checks++; if (req_ready !== (NR'(1) << g) || ram_ce !== 1'b1) $display("[TB] FAIL rnd_grant cyc %0d got %b/%b want %b/1", c, req_ready, ram_ce, NR'(1) << g); else n_pass++;
                n_checks++; if (ram_addr !== req_addr[g*AW +: AW]) $display("[TB] FAIL rnd_addr cyc %0d got %0d want %0d", c, ram_addr, req_addr[g*AW +: AW]); else n_pass++;
                n_checks++; if (ram_we !== (req_write[g] ? req_we[g*DW +: DW] : 8'h00)) $display("[TB] FAIL rnd_we cyc %0d got %h", c, ram_we); else n_pass++;
                n_checks++; if (ram_din !== (req_write[g] ? req_din[g*DW +: DW] : 8'h00)) $display("[TB] FAIL rnd_din cyc %0d got %h", c, ram_din); else n_pass++;
            end
            n_checks++; if (rsp_valid !== m_pend) $display("[TB] FAIL rnd_rsp cyc %0d got %b want %b", c, rsp_valid, m_pend); else n_pass++;
            if (m_pend != '0) begin
                n_checks++; if (rsp_data !== m_pend_data) $display("[TB] FAIL rnd_data cyc %0d got %h want %h", c, rsp_data, m_pend_data); else n_pass++;
            end
            held = req_valid;
            if (g >= 0) held[g] = 1'b0;
            model_commit();
            next_cycle();
        end
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== m_pend || rsp_data !== m_pend_data) $display("[TB] FAIL rnd_drain got %b/%h want %b/%h", rsp_valid, rsp_data, m_pend, m_pend_data); else n_pass++;
        model_commit();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00, 8'h00);
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b001) $display("[TB] FAIL flight_grant got %b want 001", req_ready); else n_pass++;
        next_cycle();
        nreset    = 1'b0;
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 3'b000) $display("[TB] FAIL flight_rsp got %b want 000", rsp_valid); else n_pass++;
        next_cycle();
        nreset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_checks++; if (ram_addr !== AW'(i) || ram_ce !== 1'b1) $display("[TB] FAIL mid_addr cyc %0d got %0d/%b want %0d/1", i, ram_addr, ram_ce, i); else n_pass++;
            next_cycle();
        end
        nreset    = 1'b0;
        req_valid = '1;
        @(negedge clk);
        n_checks++; if (ram_ce !== 1'b0 || req_ready !== 3'b000) $display("[TB] FAIL mid_reset got %b/%b want 0/000", ram_ce, req_ready); else n_pass++;
        next_cycle();
        test_init();
    endtask

    task automatic test_noinit();
        logic [AW-1:0] a;
        a           = 4'($urandom);
        nreset_b    = 1'b1;
        req_valid_b = 3'b001;
        req_write_b = '0;
        req_addr_b[AW-1:0] = a;
        @(negedge clk);
        n_checks++; if (init_done_b !== 1'b1) $display("[TB] FAIL noinit_done got %b want 1", init_done_b); else n_pass++;
        n_checks++; if (req_ready_b !== 3'b001 || ram_ce_b !== 1'b1) $display("[TB] FAIL noinit_grant got %b/%b want 001/1", req_ready_b, ram_ce_b); else n_pass++;
        n_checks++; if (ram_addr_b !== a) $display("[TB] FAIL noinit_addr got %0d want %0d", ram_addr_b, a); else n_pass++;
        next_cycle();
        req_valid_b = '0;
        @(negedge clk);
        n_checks++; if (rsp_valid_b !== 3'b001 || rsp_data_b !== 8'h3C) $display("[TB] FAIL noinit_rsp got %b/%h want 001/3c", rsp_valid_b, rsp_data_b); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++; if (rsp_valid_b !== 3'b000) $display("[TB] FAIL noinit_rsp_once got %b want 000", rsp_valid_b); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_fairness();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_noinit();
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
